// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with one outstanding imem request, one-deep hold buffer and redirect squash
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req/imem_addr         request to instruction memory (address is always the current pc)
//   imem_gnt                   memory accepted the request this cycle
//   imem_rvalid/imem_rdata     response from instruction memory
//   if_valid/if_instr/if_pc    instruction presented to decode, held stable while stalled
//   id_ready                   decode accepts the presented instruction
//   redirect_valid/redirect_pc branch/jump target; low two address bits are forced to zero
module fetch_stage #(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [31:0]       imem_rdata,
   output logic              if_valid,
   output logic [31:0]       if_instr,
   output logic [ADDR_W-1:0] if_pc,
   input  logic              id_ready,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc
);
   localparam logic [31:0] NOP = 32'h0000_0013;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
   state_t            state;
   logic [ADDR_W-1:0] pc, req_pc, hold_pc, tgt;
   logic [31:0]       hold_instr;
   logic              drop, slot_free;
   assign tgt       = redirect_pc & ~ADDR_W'(3);
   assign slot_free = !if_valid || id_ready;
   assign imem_addr = pc;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         imem_req   <= 1'b0;
         pc         <= RESET_PC;
         req_pc     <= RESET_PC;
         drop       <= 1'b0;
         if_valid   <= 1'b0;
         if_instr   <= NOP;
         if_pc      <= RESET_PC;
         hold_instr <= NOP;
         hold_pc    <= RESET_PC;
      end else begin
         // a consumed or flushed output slot empties unless a new instruction lands below
         if ((if_valid && id_ready) || redirect_valid) if_valid <= 1'b0;
         case (state)
            IDLE: begin
               state    <= REQ;
               imem_req <= 1'b1;
               if (redirect_valid) pc <= tgt;
            end
            REQ: begin
               if (imem_gnt) begin
                  // a grant coinciding with a redirect fetched a stale address: drop its response
                  state    <= WAIT;
                  imem_req <= 1'b0;
                  req_pc   <= pc;
                  pc       <= redirect_valid ? tgt : pc + ADDR_W'(4);
                  drop     <= redirect_valid;
               end else if (redirect_valid) pc <= tgt;
            end
            WAIT: begin
               if (imem_rvalid) begin
                  if (drop || redirect_valid) begin
                     state    <= REQ;
                     imem_req <= 1'b1;
                     drop     <= 1'b0;
                     if (redirect_valid) pc <= tgt;
                  end else if (slot_free) begin
                     state    <= REQ;
                     imem_req <= 1'b1;
                     if_valid <= 1'b1;
                     if_instr <= imem_rdata;
                     if_pc    <= req_pc;
                  end else begin
                     state      <= HOLD;
                     hold_instr <= imem_rdata;
                     hold_pc    <= req_pc;
                  end
               end else if (redirect_valid) begin
                  pc   <= tgt;
                  drop <= 1'b1;
               end
            end
            HOLD: begin
               if (redirect_valid) begin
                  state    <= REQ;
                  imem_req <= 1'b1;
                  pc       <= tgt;
               end else if (id_ready) begin
                  state    <= REQ;
                  imem_req <= 1'b1;
                  if_valid <= 1'b1;
                  if_instr <= hold_instr;
                  if_pc    <= hold_pc;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized memory/decode/redirect stimulus against an in-order fetch stream model
module tb_fetch_stage;
   localparam int AW = 32;
   localparam logic [AW-1:0] RPC = '0;
   localparam logic [31:0]   NOP = 32'h0000_0013;
   logic clk = 1'b0, rst_n = 1'b1;
   logic imem_req, imem_gnt, imem_rvalid, if_valid, id_ready, redirect_valid;
   logic [AW-1:0] imem_addr, if_pc, redirect_pc;
   logic [31:0] imem_rdata, if_instr;
   int checks = 0, failures = 0, xfers = 0;
   int gnt_pct, lat_lo, lat_hi, rdy_pct, redir_pct, spur_pct, lat;
   bit pending = 0, rv_real = 0, hold_resp = 0, prev_stall = 0, found;
   logic [AW-1:0] pend_addr, g_addr, exp_addr, prev_pc;
   logic [31:0] prev_instr;
   logic [AW-1:0] exp_q[$], glog[$];

   fetch_stage #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0020_8193;
   endfunction

   function automatic bit pct(input int p);
      return int'($urandom_range(99, 0)) < p;
   endfunction

   function automatic logic [AW-1:0] gl(input int i);
      return glog.size() > i ? glog[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: decode must see an unbroken +4 stream starting at the last reset/redirect
   // target, and memory must be asked for exactly that stream (a stale grant still advances it).
   task automatic restart(input logic [AW-1:0] start);
      exp_q.delete();
      exp_q.push_back(start);
      exp_addr = start;
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         restart(RPC);
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", if_valid, 1);
            chk("stall_pc", if_pc, prev_pc);
            chk("stall_instr", if_instr, prev_instr);
         end
         if (imem_req) begin
            chk("req_addr", imem_addr, exp_addr);
            if (imem_gnt) begin
               glog.push_back(imem_addr);
               exp_addr = exp_addr + 32'd4;
            end
         end
         if (if_valid && id_ready) begin
            xfers++;
            chk("if_pc", if_pc, exp_q[0]);
            chk("if_instr", if_instr, mem_word(exp_q[0]));
            exp_q.push_back(exp_q[$] + 32'd4);
            void'(exp_q.pop_front());
         end
         if (redirect_valid) restart(redirect_pc & ~32'h3);
         prev_stall = if_valid && !id_ready && !redirect_valid;
         prev_pc    = if_pc;
         prev_instr = if_instr;
      end
   end

   task automatic knobs(input int g, input int lo, input int hi, input int r, input int d, input int s);
      gnt_pct = g; lat_lo = lo; lat_hi = hi; rdy_pct = r; redir_pct = d; spur_pct = s;
   endtask

   // One clock: account for what the previous edge consumed, then drive the next cycle.
   task automatic step();
      @(posedge clk);
      #1;
      if (rst_n) begin
         if (rv_real) pending = 0;
         else if (pending && lat > 0) lat--;
         if (imem_gnt) begin
            pending   = 1;
            pend_addr = g_addr;
            lat       = int'($urandom_range(lat_hi, lat_lo));
         end
      end
      rv_real     = rst_n && pending && lat == 0 && !hold_resp;
      imem_rvalid = rv_real || (rst_n && !pending && pct(spur_pct));
      imem_rdata  = rv_real ? mem_word(pend_addr) : $urandom;
      imem_gnt    = rst_n && imem_req && pct(gnt_pct);
      g_addr      = imem_addr;
      if (imem_req) chk("one_outstanding", pending, 0);
      id_ready       = pct(rdy_pct);
      redirect_valid = rst_n && pct(redir_pct);
      redirect_pc    = pct(25) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
   endtask

   task automatic do_reset(input bit late);
      #1;
      rst_n = 0; imem_gnt = 0; imem_rvalid = 0; redirect_valid = 0; rv_real = 0; id_ready = 0;
      if (late) lat = 0; else pending = 0;
      hold_resp = late;
      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_valid", if_valid, 0);
      chk("rst_addr", imem_addr, RPC);
      chk("rst_instr", if_instr, NOP);
      chk("rst_pc", if_pc, RPC);
      repeat (2) step();
      rst_n = 1; redirect_valid = 0; imem_gnt = 0; hold_resp = 0;
      if (late) begin
         rv_real = 1; imem_rvalid = 1; imem_rdata = mem_word(pend_addr);
      end
      glog.delete();
      xfers = 0;
      step();
      chk("first_req", imem_req, 1);
   endtask

   task automatic redirect_test(input bit same_cycle, input logic [AW-1:0] target, input string name);
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         step();
         found = same_cycle ? rv_real : (pending && !rv_real && pend_addr >= 32'h8);
      end
      chk({name, "_found"}, found, 1);
      redirect_valid = 1;
      redirect_pc    = target;
      glog.delete();
      repeat (12) step();
      chk({name, "_addr"}, gl(0), target & ~32'h3);
   endtask

   initial begin
      imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; id_ready = 0; redirect_valid = 0; redirect_pc = 0;
      knobs(100, 0, 0, 100, 0, 0);
      do_reset(0);
      repeat (20) step();
      chk("zero_wait_xfers", xfers, 9);
      chk("seq_addr0", gl(0), 32'h0);
      chk("seq_addr1", gl(1), 32'h4);
      chk("seq_addr2", gl(2), 32'h8);

      knobs(100, 0, 0, 0, 0, 0);
      do_reset(0);
      repeat (8) step();
      chk("bp_grants", glog.size(), 2);
      chk("bp_req", imem_req, 0);
      chk("bp_valid", if_valid, 1);
      chk("bp_pc", if_pc, RPC);
      chk("bp_none_taken", xfers, 0);
      rdy_pct = 100; id_ready = 1;
      repeat (4) step();
      chk("bp_drain", xfers >= 2, 1);

      knobs(100, 2, 2, 100, 0, 0);
      do_reset(0);
      redirect_test(0, 32'h100, "redir_wait");
      redirect_test(1, 32'h103, "redir_rvalid");

      knobs(100, 0, 0, 100, 0, 0);
      step();
      redirect_valid = 1; redirect_pc = 32'hFFFF_FFFF; imem_gnt = 0;
      glog.delete();
      repeat (10) step();
      chk("wrap_addr0", gl(0), 32'hFFFF_FFFC);
      chk("wrap_addr1", gl(1), 32'h0);

      knobs(60, 0, 3, 70, 6, 10);
      do_reset(0);
      repeat (3000) step();
      chk("random_progress", xfers > 100, 1);

      knobs(100, 2, 2, 0, 0, 0);
      do_reset(0);
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         step();
         found = if_valid && pending && !rv_real;
      end
      chk("late_found", found, 1);
      do_reset(1);
      knobs(100, 0, 0, 100, 0, 0);
      repeat (10) step();
      chk("late_first_addr", gl(0), RPC);
      chk("late_progress", xfers >= 3, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
